// File: rtl/mem_bist_pkg.sv
// ---------------------------------------------------------------------------
// mem_bist_pkg
// Shared types and helpers for the memory BIST engine.
//   state_e      : controller FSM states
//   pat_e        : test pattern identifiers (index == bit position in pat_sel)
//   pattern_data : expected/write data for a pattern at a given address
//   find_pat     : lowest enabled pattern index at or above a starting index
// Pattern data is produced at a fixed 32-bit width and truncated by the caller,
// so memories up to 32 bits wide are supported.
// ---------------------------------------------------------------------------
package mem_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_RD_WAIT,
        ST_CHK,
        ST_NEXT,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        PAT_ZERO,
        PAT_ADDR,
        PAT_CHKB,
        PAT_ONES
    } pat_e;

    localparam logic [31:0] CHKB_EVEN = 32'h5555_5555;
    localparam logic [31:0] CHKB_ODD  = 32'hAAAA_AAAA;

    function automatic logic [31:0] pattern_data(input pat_e pat, input logic [31:0] addr);
        logic [31:0] d;
        d = '0;
        case (pat)
            PAT_ZERO: d = '0;
            PAT_ADDR: d = addr;
            PAT_CHKB: d = addr[0] ? CHKB_ODD : CHKB_EVEN;
            PAT_ONES: d = '1;
            default:  d = '0;
        endcase
        return d;
    endfunction

    // Result bit 2 flags that an enabled pattern was found; bits 1:0 hold its index.
    // Scanning downwards lets the lowest qualifying index win.
    function automatic logic [2:0] find_pat(input logic [3:0] mask, input logic [2:0] from);
        logic [2:0] r;
        r = '0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i] && (3'(i) >= from)) begin
                r = {1'b1, 2'(i)};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_bist_pattern_gen.sv
// ---------------------------------------------------------------------------
// mem_bist_pattern_gen
// Combinational pattern generator shared by the write path (data_in) and the
// check path (expected read data).
// Ports:
//   pat   in  2       pattern index (pat_e encoding)
//   addr  in  ADDR_W  memory address
//   data  out DATA_W  pattern value for that address
// ---------------------------------------------------------------------------
module mem_bist_pattern_gen
    import mem_bist_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic [1:0]        pat,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    assign data = DATA_W'(pattern_data(pat_e'(pat), 32'(addr)));

endmodule

// File: rtl/mem_bist_ctrl.sv
// ---------------------------------------------------------------------------
// mem_bist_ctrl
// Memory built-in self-test engine. For each enabled pattern it writes every
// address, then reads each address back and compares against the pattern.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, abort, pat_sel run control and pattern enable mask
//   read, write, addr,    memory interface (single-port synchronous memory)
//   data_in, data_out
//   busy, done, pass      run status
//   err_cnt, cur_pat      saturating mismatch count, active pattern index
// Optional feature (macro MEM_BIST_ERRLOG_EN): fail_addr, fail_data, fail_exp,
// fail_pat capture the first mismatch of a run.
// ---------------------------------------------------------------------------
module mem_bist_ctrl
    import mem_bist_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [3:0]        pat_sel,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [1:0]        cur_pat
`ifdef MEM_BIST_ERRLOG_EN
    ,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [DATA_W-1:0] fail_exp,
    output logic [1:0]        fail_pat
`endif
);

    // RD_WAIT runs for RD_LAT-1 cycles; the counter's final value ends the wait.
    localparam logic [1:0] WAIT_LAST = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        cur_pat_q, cur_pat_d;
    logic [3:0]        mask_q, mask_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic [1:0]        wait_q, wait_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [DATA_W-1:0] pat_data;
    logic [2:0]        first_pat;
    logic [2:0]        next_pat;
    logic              last_addr;
    logic              mismatch;
    logic              in_run;
    logic              accept_start;
    logic              do_abort;

    mem_bist_pattern_gen #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_pattern_gen (
        .pat  (cur_pat_q),
        .addr (addr_q),
        .data (pat_data)
    );

    // The mask is captured at start so pattern sequencing is immune to pat_sel changing mid-run.
    assign first_pat    = find_pat(pat_sel, 3'd0);
    assign next_pat     = find_pat(mask_q, {1'b0, cur_pat_q} + 3'd1);
    assign last_addr    = (addr_q == {ADDR_W{1'b1}});
    assign mismatch     = (data_out !== pat_data);
    assign in_run       = state_q inside {ST_WR, ST_RD, ST_RD_WAIT, ST_CHK, ST_NEXT};
    assign accept_start = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign do_abort     = abort && in_run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start) state_d = first_pat[2] ? ST_WR : ST_DONE;
            ST_WR:            if (last_addr) state_d = ST_RD;
            ST_RD:            state_d = (RD_LAT == 1) ? ST_CHK : ST_RD_WAIT;
            ST_RD_WAIT:       if (wait_q == WAIT_LAST) state_d = ST_CHK;
            ST_CHK:           state_d = last_addr ? ST_NEXT : ST_RD;
            ST_NEXT:          state_d = next_pat[2] ? ST_WR : ST_DONE;
            default:          state_d = ST_IDLE;
        endcase
        if (do_abort) state_d = ST_IDLE;
    end

    // Datapath registers; addr only moves on entry to a strobe cycle so it holds otherwise.
    always_comb begin
        addr_d    = addr_q;
        cur_pat_d = cur_pat_q;
        mask_d    = mask_q;
        err_cnt_d = err_cnt_q;
        wait_d    = wait_q;
        wdata_d   = wdata_q;
        if (accept_start) begin
            err_cnt_d = '0;
            mask_d    = pat_sel;
            cur_pat_d = first_pat[1:0];
            if (first_pat[2]) addr_d = '0;
        end else if (!do_abort) begin
            case (state_q)
                ST_WR: begin
                    wdata_d = pat_data;
                    addr_d  = last_addr ? '0 : addr_q + 1'b1;
                end
                ST_RD:      wait_d = '0;
                ST_RD_WAIT: wait_d = wait_q + 2'd1;
                ST_CHK: begin
                    if (mismatch && (err_cnt_q != {ERR_W{1'b1}})) err_cnt_d = err_cnt_q + 1'b1;
                    if (!last_addr) addr_d = addr_q + 1'b1;
                end
                ST_NEXT: begin
                    if (next_pat[2]) begin
                        cur_pat_d = next_pat[1:0];
                        addr_d    = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            cur_pat_q <= '0;
            mask_q    <= '0;
            err_cnt_q <= '0;
            wait_q    <= '0;
            wdata_q   <= '0;
        end else begin
            addr_q    <= addr_d;
            cur_pat_q <= cur_pat_d;
            mask_q    <= mask_d;
            err_cnt_q <= err_cnt_d;
            wait_q    <= wait_d;
            wdata_q   <= wdata_d;
        end
    end

    // Strobes decode straight from the state flop, so an async reset drops them at once.
    always_comb begin
        read  = 1'b0;
        write = 1'b0;
        busy  = in_run;
        done  = 1'b0;
        case (state_q)
            ST_WR:   write = 1'b1;
            ST_RD:   read  = 1'b1;
            ST_DONE: done  = 1'b1;
            default: ;
        endcase
        data_in = (state_q == ST_WR) ? pat_data : wdata_q;
        addr    = addr_q;
        err_cnt = err_cnt_q;
        cur_pat = cur_pat_q;
        pass    = done && (err_cnt_q == '0);
    end

`ifdef MEM_BIST_ERRLOG_EN
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] fail_data_q, fail_data_d;
    logic [DATA_W-1:0] fail_exp_q, fail_exp_d;
    logic [1:0]        fail_pat_q, fail_pat_d;

    // err_cnt never decreases within a run, so a zero count marks the first mismatch.
    always_comb begin
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        fail_exp_d  = fail_exp_q;
        fail_pat_d  = fail_pat_q;
        if (accept_start) begin
            fail_addr_d = '0;
            fail_data_d = '0;
            fail_exp_d  = '0;
            fail_pat_d  = '0;
        end else if (!do_abort && (state_q == ST_CHK) && mismatch && (err_cnt_q == '0)) begin
            fail_addr_d = addr_q;
            fail_data_d = data_out;
            fail_exp_d  = pat_data;
            fail_pat_d  = cur_pat_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_addr_q <= '0;
            fail_data_q <= '0;
            fail_exp_q  <= '0;
            fail_pat_q  <= '0;
        end else begin
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            fail_exp_q  <= fail_exp_d;
            fail_pat_q  <= fail_pat_d;
        end
    end

    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
    assign fail_exp  = fail_exp_q;
    assign fail_pat  = fail_pat_q;
`endif

endmodule
